// File: rtl/xbus_sram_pkg.sv
// Shared definitions for the xbus SRAM controller: FSM state encoding and
// halfword select values used to form the SRAM halfword address.
package xbus_sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_GAP  = 3'd2,
        S_HI   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic HW_LO = 1'b0;
    localparam logic HW_HI = 1'b1;

endpackage

// File: rtl/xbus_sram_ctl.sv
// Splits one 32-bit xbus memory request into two 16-bit asynchronous SRAM
// accesses (low halfword first) and returns a one-cycle completion pulse.
module xbus_sram_ctl
    import xbus_sram_pkg::*;
#(
    parameter int ADDR_BITS   = 18,
    parameter int WAIT_CYCLES = 2
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [21:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic                 mem_rd_req,
    input  logic                 mem_wr_req,
    output logic [31:0]          mem_rdata,
    output logic                 mem_rd_ready,
    output logic                 mem_wr_done,
    output logic                 busy,
    output logic [ADDR_BITS:0]   sram_a,
    output logic [15:0]          sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [15:0]          sram_dq_in,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] PHASE_FIRST = CW'(1);
    localparam logic [CW-1:0] PHASE_LAST  = CW'(WAIT_CYCLES);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_armed;
    logic                  r_is_write, w_is_write_nxt;
    logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [31:0]           r_rdata;
    logic [ADDR_BITS:0]    r_sram_a, w_sram_a;
    logic [15:0]           r_dq_out, w_dq_out;
    logic                  r_dq_oe, w_dq_oe;
    logic                  r_ce_n, w_ce_n;
    logic                  r_oe_n, w_oe_n;
    logic                  r_we_n, w_we_n;
    logic                  w_accept;
    logic                  w_unused_addr_hi;

    assign w_unused_addr_hi = ^mem_addr[21:ADDR_BITS];

    assign w_accept = (r_state == S_IDLE) && r_armed && (mem_rd_req || mem_wr_req);

    // Next-state logic, then SRAM pin values decoded from the *next* state so
    // the pins come straight out of flops and never glitch toward the SRAM.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_is_write_nxt = r_is_write;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_ce_n         = 1'b1;
        w_oe_n         = 1'b1;
        w_we_n         = 1'b1;
        w_dq_oe        = 1'b0;
        w_dq_out       = r_dq_out;
        w_sram_a       = r_sram_a;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_LO;
                    w_cnt_nxt      = PHASE_FIRST;
                    w_is_write_nxt = mem_wr_req;
                    w_addr_nxt     = mem_addr[ADDR_BITS-1:0];
                    w_wdata_nxt    = mem_wdata;
                end
            end
            S_LO: begin
                if (r_cnt == PHASE_LAST) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + PHASE_FIRST;
                end
            end
            S_GAP: begin
                w_state_nxt = S_HI;
                w_cnt_nxt   = PHASE_FIRST;
            end
            S_HI: begin
                if (r_cnt == PHASE_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + PHASE_FIRST;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Phase cycle 1 and GAP keep WE high for address setup and hold.
        if (w_state_nxt inside {S_LO, S_GAP, S_HI}) begin
            w_ce_n   = 1'b0;
            w_sram_a = {w_addr_nxt, (w_state_nxt == S_HI) ? HW_HI : HW_LO};
            if (w_is_write_nxt) begin
                w_dq_oe  = 1'b1;
                w_dq_out = (w_state_nxt == S_HI) ? w_wdata_nxt[31:16] : w_wdata_nxt[15:0];
                w_we_n   = (w_state_nxt == S_GAP) || (w_cnt_nxt == PHASE_FIRST);
            end else begin
                w_oe_n = (w_state_nxt == S_GAP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_sram_a   <= '0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_is_write <= w_is_write_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_sram_a   <= w_sram_a;
            r_dq_out   <= w_dq_out;
            r_dq_oe    <= w_dq_oe;
            r_ce_n     <= w_ce_n;
            r_oe_n     <= w_oe_n;
            r_we_n     <= w_we_n;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!mem_rd_req && !mem_wr_req) begin
                r_armed <= 1'b1;
            end
            // Read data is captured on the last strobe cycle of each phase.
            if (!r_is_write && (r_cnt == PHASE_LAST)) begin
                if (r_state == S_LO) r_rdata[15:0]  <= sram_dq_in;
                if (r_state == S_HI) r_rdata[31:16] <= sram_dq_in;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign mem_rd_ready = (r_state == S_DONE) && !r_is_write;
    assign mem_wr_done  = (r_state == S_DONE) && r_is_write;
    assign mem_rdata    = r_rdata;
    assign sram_a       = r_sram_a;
    assign sram_dq_out  = r_dq_out;
    assign sram_dq_oe   = r_dq_oe;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;
    assign sram_ub_n    = r_ce_n;
    assign sram_lb_n    = r_ce_n;

endmodule
